// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared types, counter constants and the saturating counter
//                step used by the branch predictor and its BTB.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // Widest tag / target the BTB read-port struct can carry; real storage is
  // sized by the instantiating module and zero-extended into these fields.
  localparam int unsigned BTB_TAG_MAX  = 32;
  localparam int unsigned BTB_ADDR_MAX = 64;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_MAX-1:0]  tag;
    logic [BTB_ADDR_MAX-1:0] target;
  } btb_entry_t;

  // Weakly-not-taken: one below the taken threshold.
  function automatic logic [31:0] cnt_reset_val(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Smallest counter value that predicts taken (MSB set).
  function automatic logic [31:0] cnt_taken_thresh(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic logic [31:0] cnt_max_val(input int unsigned w);
    return 32'hFFFF_FFFF >> (32 - w);
  endfunction

  // One saturating step of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_step(input logic [31:0] cnt, input logic up,
                                           input int unsigned w);
    logic [31:0] res;
    res = cnt;
    if (up) begin
      if (cnt != cnt_max_val(w)) res = cnt + 32'd1;
    end else begin
      if (cnt != 32'd0) res = cnt - 32'd1;
    end
    return res;
  endfunction

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_btb.sv
`default_nettype none
// ============================================================================
//  Module      : bp_btb
//  Description : Branch target buffer. Direct-mapped valid/tag/target array
//                with a combinational read port, a synchronous write port and
//                asynchronous active-low clearing of the valid bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_btb
  import bp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output btb_entry_t       rd_entry_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [XLEN-1:0]  wr_target_i
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];

  // Combinational read, fields zero-extended into the shared entry struct.
  always_comb begin
    rd_entry_o                    = '0;
    rd_entry_o.valid              = valid_q[rd_idx_i];
    rd_entry_o.tag[TAG_W-1:0]     = tag_q[rd_idx_i];
    rd_entry_o.target[XLEN-1:0]   = target_q[rd_idx_i];
  end

  // Valid bits: the only BTB state that needs a reset value.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and target payload; meaningless until the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]    <= wr_tag_i;
      target_q[wr_idx_i] <= wr_target_i;
    end
  end

endmodule : bp_btb
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Dynamic branch predictor (BHT of saturating counters + BTB)
//                for the IF stage, trained by branch outcomes from ID.
//                Define GSHARE_EN to XOR global history into the BHT index;
//                without it the BHT is bimodal and pred_ghr_o is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned GHR_W   = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_target_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic             upd_taken_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic             upd_pred_taken_i,
  input  logic [XLEN-1:0]  upd_pred_target_i,
  input  logic [GHR_W-1:0] upd_ghr_i,
  output logic             mispredict_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [31:0]      br_cnt_o,
  output logic [31:0]      miss_cnt_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] lk_pc_idx, upd_pc_idx;
  logic [IDX_W-1:0] lk_bht_idx, upd_bht_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_accept;
  btb_entry_t       btb_rd;
  logic             btb_hit;

  logic [CNT_W-1:0] bht_q [ENTRIES];
  logic [CNT_W-1:0] bht_lk, bht_upd, bht_d;
  logic [31:0]      br_cnt_q, br_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;

  assign lk_pc_idx  = pc_i[IDX_W+1:2];
  assign lk_tag     = pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_pc_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag    = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

  // Gating on rst_i keeps a resolution arriving during reset from flushing.
  assign upd_accept = upd_valid_i & start_i & rst_i;

`ifdef GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  assign lk_bht_idx  = lk_pc_idx ^ IDX_W'(ghr_q);
  assign upd_bht_idx = upd_pc_idx ^ IDX_W'(upd_ghr_i);
  assign ghr_d       = upd_accept ? ((ghr_q << 1) | GHR_W'(upd_taken_i)) : ghr_q;
  assign pred_ghr_o  = ghr_q;

  // Global history shifts in every accepted outcome.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end
`else
  assign lk_bht_idx  = lk_pc_idx;
  assign upd_bht_idx = upd_pc_idx;
  assign pred_ghr_o  = '0;
`endif

  bp_btb #(
    .XLEN    (XLEN),
    .ENTRIES (ENTRIES),
    .TAG_W   (TAG_W),
    .IDX_W   (IDX_W)
  ) u_btb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_idx_i    (lk_pc_idx),
    .rd_entry_o  (btb_rd),
    .wr_en_i     (upd_accept & upd_taken_i),
    .wr_idx_i    (upd_pc_idx),
    .wr_tag_i    (upd_tag),
    .wr_target_i (upd_target_i)
  );

  assign btb_hit = btb_rd.valid && (btb_rd.tag[TAG_W-1:0] == lk_tag);
  assign bht_lk  = bht_q[lk_bht_idx];
  assign bht_upd = bht_q[upd_bht_idx];
  assign bht_d   = CNT_W'(sat_step(32'(bht_upd), upd_taken_i, CNT_W));

  // Lookup: counter must say taken and the BTB must supply a target.
  always_comb begin
    pred_taken_o  = start_i & rst_i & btb_hit &
                    (32'(bht_lk) >= cnt_taken_thresh(CNT_W));
    pred_target_o = pred_taken_o ? btb_rd.target[XLEN-1:0] : pc_i + XLEN'(4);
  end

  // Resolution: wrong direction, or right taken direction with wrong target.
  always_comb begin
    mispredict_o  = upd_accept &
                    ((upd_taken_i != upd_pred_taken_i) |
                     (upd_taken_i & upd_pred_taken_i &
                      (upd_target_i != upd_pred_target_i)));
    redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4);
  end

  // BHT counters train only on accepted updates; reset to weakly-not-taken.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= CNT_W'(cnt_reset_val(CNT_W));
    end else if (upd_accept) begin
      bht_q[upd_bht_idx] <= bht_d;
    end
  end

  assign br_cnt_d   = upd_accept   ? sat_step(br_cnt_q, 1'b1, 32)   : br_cnt_q;
  assign miss_cnt_d = mispredict_o ? sat_step(miss_cnt_q, 1'b1, 32) : miss_cnt_q;

  // Saturating performance counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign br_cnt_o   = br_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

  // Address bits outside the index/tag fields (and history in bimodal mode)
  // carry no information for the tables; fold them so they are consumed.
  logic unused_ok;
  assign unused_ok = ^{pc_i, upd_pc_i, upd_ghr_i, btb_rd};

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Directed self-checking bench for branch_predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned GHR_W = 6;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic [XLEN-1:0]  pc_i = '0;
  logic             pred_taken_o;
  logic [XLEN-1:0]  pred_target_o;
  logic [GHR_W-1:0] pred_ghr_o;
  logic             upd_valid_i = 1'b0;
  logic [XLEN-1:0]  upd_pc_i = '0;
  logic             upd_taken_i = 1'b0;
  logic [XLEN-1:0]  upd_target_i = '0;
  logic             upd_pred_taken_i = 1'b0;
  logic [XLEN-1:0]  upd_pred_target_i = '0;
  logic [GHR_W-1:0] upd_ghr_i = '0;
  logic             mispredict_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic [31:0]      br_cnt_o;
  logic [31:0]      miss_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  branch_predictor dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .pc_i              (pc_i),
    .pred_taken_o      (pred_taken_o),
    .pred_target_o     (pred_target_o),
    .pred_ghr_o        (pred_ghr_o),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_taken_i       (upd_taken_i),
    .upd_target_i      (upd_target_i),
    .upd_pred_taken_i  (upd_pred_taken_i),
    .upd_pred_target_i (upd_pred_target_i),
    .upd_ghr_i         (upd_ghr_i),
    .mispredict_o      (mispredict_o),
    .redirect_pc_o     (redirect_pc_o),
    .br_cnt_o          (br_cnt_o),
    .miss_cnt_o        (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic ptaken, input logic [31:0] ptgt, input logic [5:0] ghr);
    upd_valid_i       = 1'b1;
    upd_pc_i          = pc;
    upd_taken_i       = taken;
    upd_target_i      = tgt;
    upd_pred_taken_i  = ptaken;
    upd_pred_target_i = ptgt;
    upd_ghr_i         = ghr;
    #1;
  endtask

  task automatic idle();
    upd_valid_i = 1'b0;
    #1;
  endtask

  initial begin
    // ---------------- reset, with a would-be mispredict presented ----------
    #1;
    rst_i   = 1'b0;
    start_i = 1'b1;
    pc_i    = 32'h100;
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 6'd0);
    #1;
    chk("rst_taken",  32'(pred_taken_o), 32'd0);
    chk("rst_target", pred_target_o, 32'h104);
    chk("rst_misp",   32'(mispredict_o), 32'd0);
    chk("rst_br",     br_cnt_o, 32'd0);
    chk("rst_miss",   miss_cnt_o, 32'd0);
    chk("rst_ghr",    32'(pred_ghr_o), 32'd0);
    step();                      // edge under reset: update must be dropped
    rst_i = 1'b1;
    idle();
    chk("post_rst_taken",  32'(pred_taken_o), 32'd0);
    chk("post_rst_target", pred_target_o, 32'h104);
    chk("post_rst_br",     br_cnt_o, 32'd0);

`ifndef GSHARE_EN
    // ---------------- training: 01 -> 10 -> 11 -----------------------------
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 6'd0);
    chk("t1_misp",     32'(mispredict_o), 32'd1);
    chk("t1_redirect", redirect_pc_o, 32'h80);
    step(); idle();
    chk("t1_taken",  32'(pred_taken_o), 32'd1);
    chk("t1_target", pred_target_o, 32'h80);
    chk("t1_br",     br_cnt_o, 32'd1);
    chk("t1_miss",   miss_cnt_o, 32'd1);
    upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 6'd0);
    chk("t2_misp", 32'(mispredict_o), 32'd0);
    step(); idle();
    chk("t2_taken", 32'(pred_taken_o), 32'd1);
    chk("t2_br",    br_cnt_o, 32'd2);
    chk("t2_miss",  miss_cnt_o, 32'd1);

    // ---------------- four not-taken: 11 -> 10 -> 01 -> 00 -> 00 -----------
    for (int i = 0; i < 4; i++) begin
      upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h104, 6'd0);
      step();
    end
    idle();
    chk("nt_taken",  32'(pred_taken_o), 32'd0);
    chk("nt_target", pred_target_o, 32'h104);
    chk("nt_br",     br_cnt_o, 32'd6);
    chk("nt_miss",   miss_cnt_o, 32'd1);
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 6'd0);   // 00 -> 01
    chk("t3_misp", 32'(mispredict_o), 32'd1);
    step(); idle();
    chk("t3_taken", 32'(pred_taken_o), 32'd0);
    chk("t3_miss",  miss_cnt_o, 32'd2);
    chk("t3_br",    br_cnt_o, 32'd7);

    // ---------------- wrong target + same-cycle lookup (01 -> 10) -----------
    pc_i = 32'h100;
    upd(32'h100, 1'b1, 32'h40, 1'b1, 32'h80, 6'd0);
    chk("tgt_misp",       32'(mispredict_o), 32'd1);
    chk("tgt_redirect",   redirect_pc_o, 32'h40);
    chk("same_cyc_taken", 32'(pred_taken_o), 32'd0);
    chk("tgt_miss_pre",   miss_cnt_o, 32'd2);
    step(); idle();
    chk("next_cyc_taken",  32'(pred_taken_o), 32'd1);
    chk("next_cyc_target", pred_target_o, 32'h40);
    chk("tgt_miss_post",   miss_cnt_o, 32'd3);

    // ---------------- not-taken redirect goes to pc+4 -----------------------
    upd(32'h204, 1'b0, 32'h999, 1'b1, 32'h40, 6'd0);
    chk("nt_misp",     32'(mispredict_o), 32'd1);
    chk("nt_redirect", redirect_pc_o, 32'h208);
    step(); idle();
    chk("nt_br2",   br_cnt_o, 32'd9);
    chk("nt_miss2", miss_cnt_o, 32'd4);

    // ---------------- start low: no prediction, no update -------------------
    start_i = 1'b0;
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h40, 6'd0);
    chk("stop_misp",   32'(mispredict_o), 32'd0);
    chk("stop_taken",  32'(pred_taken_o), 32'd0);
    chk("stop_target", pred_target_o, 32'h104);
    step();
    start_i = 1'b1;
    idle();
    chk("stop_br",     br_cnt_o, 32'd9);
    chk("stop_miss",   miss_cnt_o, 32'd4);
    chk("stop_hold",   32'(pred_taken_o), 32'd1);

    // ---------------- tag miss on aliasing index; pc+4 wrap -----------------
    pc_i = 32'h200;
    #1;
    chk("tagmiss_taken",  32'(pred_taken_o), 32'd0);
    chk("tagmiss_target", pred_target_o, 32'h204);
    pc_i = 32'hFFFF_FFFC;
    #1;
    chk("wrap_target", pred_target_o, 32'h0);
`endif

    // ---------------- mid-run reset clears everything -----------------------
    pc_i  = 32'h100;
    rst_i = 1'b0;
    #1;
    chk("rst2_taken",  32'(pred_taken_o), 32'd0);
    chk("rst2_target", pred_target_o, 32'h104);
    chk("rst2_br",     br_cnt_o, 32'd0);
    chk("rst2_miss",   miss_cnt_o, 32'd0);
    step();
    rst_i = 1'b1;
    #1;

    // ---------------- history: same PC, GHR 0 vs 1 --------------------------
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 6'd0);
    step();
    upd(32'h100, 1'b0, 32'h0,  1'b0, 32'h104, 6'd1);
    step();
    // Five not-taken elsewhere flush the history back to zero.
    for (int i = 0; i < 5; i++) begin
      upd(32'h180, 1'b0, 32'h0, 1'b0, 32'h184, 6'd0);
      step();
    end
    idle();
    pc_i = 32'h100;
    #1;
    chk("hist_ghr", 32'(pred_ghr_o), 32'd0);
    chk("hist_br",  br_cnt_o, 32'd7);
`ifdef GSHARE_EN
    chk("hist_taken",  32'(pred_taken_o), 32'd1);
    chk("hist_target", pred_target_o, 32'h80);
`else
    chk("hist_taken",  32'(pred_taken_o), 32'd0);
    chk("hist_target", pred_target_o, 32'h104);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_branch_predictor
`default_nettype wire
